// File: rtl/div8_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div8_pkg;

    localparam int WIDTH = 8;

    localparam logic [WIDTH-1:0] DIV0_QUOTIENT = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

endpackage

// File: rtl/div8_step.sv
// One restoring-division iteration: trial-subtract the divisor from the shifted
// partial remainder and produce the new remainder and one quotient bit.
module div8_step
    import div8_pkg::*;
#(
    parameter int WIDTH = div8_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] r_in,
    input  logic             d_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] r_out,
    output logic             q_bit
);

    logic [WIDTH:0] trial;

    always_comb begin
        // One extra bit keeps the borrow visible; r_in < divisor guarantees no overflow.
        trial = {r_in, d_bit} - {1'b0, divisor};
        q_bit = ~trial[WIDTH];
        r_out = trial[WIDTH] ? {r_in[WIDTH-2:0], d_bit} : trial[WIDTH-1:0];
    end

endmodule

// File: rtl/div8_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/done
// handshake, results held in registers until the next completed division.
module div8_seq
    import div8_pkg::*;
#(
    parameter int WIDTH = div8_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero,
    output logic             Z
);

    localparam int CW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_zero_q, div_zero_d;
    logic             z_q, z_d;

    logic [WIDTH-1:0] step_r;
    logic             step_q;
    logic [WIDTH-1:0] q_final;

    div8_step #(.WIDTH(WIDTH)) u_step (
        .r_in    (r_q),
        .d_bit   (d_q[WIDTH-1]),
        .divisor (dvs_q),
        .r_out   (step_r),
        .q_bit   (step_q)
    );

    assign q_final = {q_q[WIDTH-2:0], step_q};

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        d_d         = d_q;
        dvs_d       = dvs_q;
        r_d         = r_q;
        q_d         = q_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;
        z_d         = z_q;

        case (state_q)
            CALC: begin
                d_d     = {d_q[WIDTH-2:0], 1'b0};
                r_d     = step_r;
                q_d     = q_final;
                count_d = count_q + 1'b1;
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d     = DONE;
                    quotient_d  = q_final;
                    remainder_d = step_r;
                    div_zero_d  = 1'b0;
                    z_d         = (q_final == '0);
                end
            end
            default: begin
                // IDLE and DONE both accept a new request.
                state_d = IDLE;
                if (start) begin
                    d_d   = dividend;
                    dvs_d = divisor;
                    if (divisor == '0) begin
                        state_d     = DONE;
                        quotient_d  = WIDTH'(DIV0_QUOTIENT);
                        remainder_d = dividend;
                        div_zero_d  = 1'b1;
                        z_d         = 1'b0;
                    end else begin
                        state_d = CALC;
                        count_d = '0;
                        r_d     = '0;
                        q_d     = '0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            d_q         <= '0;
            dvs_q       <= '0;
            r_q         <= '0;
            q_q         <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
            z_q         <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            d_q         <= d_d;
            dvs_q       <= dvs_d;
            r_q         <= r_d;
            q_q         <= q_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
            z_q         <= z_d;
        end
    end

    assign ready     = (state_q != CALC);
    assign done      = (state_q == DONE);
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;
    assign Z         = z_q;

endmodule

// File: tb/tb_div8_seq.sv
// Directed and randomized checks of div8_seq: results, flags, latency and handshake.
module tb_div8_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       ready;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_zero;
    logic       Z;

    int checks = 0;
    int errors = 0;

    div8_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .ready     (ready),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .Z         (Z)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    // Called at #1 after a rising edge. lat counts cycles from the accept edge:
    // lat=1 is the cycle right after it. nrdy counts cycles with ready=0 before done.
    task automatic run_div(input logic [7:0] a, input logic [7:0] b,
                           output logic [7:0] q, output logic [7:0] r,
                           output logic dz, output logic z,
                           output int lat, output int nrdy);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
        lat  = 1;
        nrdy = 0;
        while (done !== 1'b1 && lat < 20) begin
            if (ready === 1'b0) nrdy++;
            @(posedge clk); #1;
            lat++;
        end
        q  = quotient;
        r  = remainder;
        dz = div_zero;
        z  = Z;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; dividend = 8'd0; divisor = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({ready, done, quotient, remainder, div_zero, Z} !== {1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b done=%b q=%0d r=%0d dz=%b z=%b, want rdy=1 done=0 q=0 r=0 dz=0 z=0",
                     ready, done, quotient, remainder, div_zero, Z);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [7:0] q, r; logic dz, z; int lat, nrdy;
        run_div(8'd200, 8'd7, q, r, dz, z, lat, nrdy);
        checks++;
        if ({q, r, dz, z} !== {8'd28, 8'd4, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL basic_200_7: got q=%0d r=%0d dz=%b z=%b, want q=28 r=4 dz=0 z=0", q, r, dz, z);
        end
        checks++;
        if (lat !== 9 || nrdy !== 8) begin
            errors++;
            $display("FAIL basic_timing: got lat=%0d busy=%0d, want lat=9 busy=8", lat, nrdy);
        end
        @(posedge clk); #1;
        checks++;
        if ({done, ready, quotient, remainder} !== {1'b0, 1'b1, 8'd28, 8'd4}) begin
            errors++;
            $display("FAIL basic_hold: got done=%b rdy=%b q=%0d r=%0d, want done=0 rdy=1 q=28 r=4",
                     done, ready, quotient, remainder);
        end
    endtask

    task automatic test_boundaries();
        logic [7:0] ta [4] = '{8'd255, 8'd255, 8'd5, 8'd0};
        logic [7:0] tb [4] = '{8'd1,   8'd255, 8'd9, 8'd3};
        logic [7:0] eq [4] = '{8'd255, 8'd1,   8'd0, 8'd0};
        logic [7:0] er [4] = '{8'd0,   8'd0,   8'd5, 8'd0};
        logic       ez [4] = '{1'b0,   1'b0,   1'b1, 1'b1};
        logic [7:0] q, r; logic dz, z; int lat, nrdy;
        for (int i = 0; i < 4; i++) begin
            run_div(ta[i], tb[i], q, r, dz, z, lat, nrdy);
            checks++;
            if ({q, r, dz, z, lat[7:0]} !== {eq[i], er[i], 1'b0, ez[i], 8'd9}) begin
                errors++;
                $display("FAIL boundary_%0d_%0d: got q=%0d r=%0d dz=%b z=%b lat=%0d, want q=%0d r=%0d dz=0 z=%b lat=9",
                         ta[i], tb[i], q, r, dz, z, lat, eq[i], er[i], ez[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_div_zero();
        logic [7:0] q, r; logic dz, z; int lat, nrdy;
        run_div(8'd77, 8'd0, q, r, dz, z, lat, nrdy);
        checks++;
        if ({q, r, dz, z, lat[7:0]} !== {8'hFF, 8'd77, 1'b1, 1'b0, 8'd1}) begin
            errors++;
            $display("FAIL div_zero_77: got q=%0h r=%0d dz=%b z=%b lat=%0d, want q=ff r=77 dz=1 z=0 lat=1",
                     q, r, dz, z, lat);
        end
        @(posedge clk); #1;
        run_div(8'd10, 8'd3, q, r, dz, z, lat, nrdy);
        checks++;
        if ({q, r, dz, z, lat[7:0]} !== {8'd3, 8'd1, 1'b0, 1'b0, 8'd9}) begin
            errors++;
            $display("FAIL after_div_zero_10_3: got q=%0d r=%0d dz=%b z=%b lat=%0d, want q=3 r=1 dz=0 z=0 lat=9",
                     q, r, dz, z, lat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_busy_reject();
        int lat, extra;
        start = 1'b1; dividend = 8'd100; divisor = 8'd10;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 20) begin
            start = (lat == 4); dividend = 8'd9; divisor = 8'd2;
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
        end
        checks++;
        if ({quotient, remainder, lat[7:0]} !== {8'd10, 8'd0, 8'd9}) begin
            errors++;
            $display("FAIL busy_reject: got q=%0d r=%0d lat=%0d, want q=10 r=0 lat=9", quotient, remainder, lat);
        end
        extra = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done === 1'b1) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL busy_no_queue: got %0d extra done pulses, want 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] q, r; logic dz, z; int lat, nrdy;
        run_div(8'd100, 8'd10, q, r, dz, z, lat, nrdy);
        run_div(8'd9, 8'd2, q, r, dz, z, lat, nrdy);
        checks++;
        if ({q, r, dz, z, lat[7:0]} !== {8'd4, 8'd1, 1'b0, 1'b0, 8'd9}) begin
            errors++;
            $display("FAIL back_to_back_9_2: got q=%0d r=%0d dz=%b z=%b lat=%0d, want q=4 r=1 dz=0 z=0 lat=9",
                     q, r, dz, z, lat);
        end
    endtask

    task automatic test_rst_abort();
        logic [7:0] q, r; logic dz, z; int lat, nrdy, n_done;
        start = 1'b1; dividend = 8'd200; divisor = 8'd7;
        @(posedge clk); #1;
        start = 1'b0;
        n_done = 0;
        for (int i = 1; i < 5; i++) begin
            if (done === 1'b1) n_done++;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        if (done === 1'b1) n_done++;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({n_done[7:0], done, ready, quotient, remainder, div_zero, Z} !==
            {8'd0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rst_abort: got dones=%0d done=%b rdy=%b q=%0d r=%0d dz=%b z=%b, want dones=0 done=0 rdy=1 q=0 r=0 dz=0 z=0",
                     n_done, done, ready, quotient, remainder, div_zero, Z);
        end
        run_div(8'd50, 8'd6, q, r, dz, z, lat, nrdy);
        checks++;
        if ({q, r, dz, z, lat[7:0]} !== {8'd8, 8'd2, 1'b0, 1'b0, 8'd9}) begin
            errors++;
            $display("FAIL after_rst_50_6: got q=%0d r=%0d dz=%b z=%b lat=%0d, want q=8 r=2 dz=0 z=0 lat=9",
                     q, r, dz, z, lat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [7:0] a, b, q, r, eq, er; logic dz, z, ez, edz; int lat, nrdy, elat;
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom_range(0, 255));
            b = (i % 8 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            if (b == 8'd0) begin
                eq = 8'hFF; er = a; edz = 1'b1; ez = 1'b0; elat = 1;
            end else begin
                eq = a / b; er = a % b; edz = 1'b0; ez = (a < b); elat = 9;
            end
            run_div(a, b, q, r, dz, z, lat, nrdy);
            checks++;
            if ({q, r, dz, z, lat[7:0]} !== {eq, er, edz, ez, elat[7:0]}) begin
                errors++;
                $display("FAIL random_%0d_%0d: got q=%0d r=%0d dz=%b z=%b lat=%0d, want q=%0d r=%0d dz=%b z=%b lat=%0d",
                         a, b, q, r, dz, z, lat, eq, er, edz, ez, elat);
            end
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_div_zero();
        test_busy_reject();
        test_back_to_back();
        test_rst_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
